and_or_rr_sched: RTL
====================

Name: and_or_rr_sched

Overview:
- Round-robin scheduler that shares one registered and-or evaluation stage among NREQ requesters.
- Each requester presents four operand words over a valid/ready handshake.
- The block grants one requester per cycle and evaluates (a&b)|(c&d) bitwise.
- It returns the result with the winner's ID through a single-entry output register with valid/ready backpressure.
- It sits between multiple sequencing agents and the downstream consumer of and-or results.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, operand/result width in bits.
- CNTW, 16, width of accepted-transaction counter.
- IDW, derived localparam $clog2(NREQ), requester ID width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept (one-hot or zero).
- req_a  input  NREQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH]; same packing for req_b, req_c, req_d.
- req_b  input  NREQ*WIDTH  operand b.
- req_c  input  NREQ*WIDTH  operand c.
- req_d  input  NREQ*WIDTH  operand d.
- out_valid  output  1  result register holds valid data.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  (a&b)|(c&d) of the granted request.
- out_id  output  IDW  index of the granted requester.
- acc_cnt  output  CNTW  total requests accepted since reset.

Behaviour:
- Reset is synchronous (rst high at a clk edge):
  - out_valid=0, out_data=0, out_id=0, acc_cnt=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - req_ready=0 while rst is high.
- Slot free: slot_free = !out_valid | out_ready.
- Grant (combinational):
  - If slot_free and any req_valid, grant the first valid requester scanning ptr, ptr+1, ..., wrapping mod NREQ.
  - req_ready[g]=1 for the grant g; all other bits are 0.
  - If there is no grant, req_ready=0.
- Request protocol:
  - req_ready may depend on req_valid.
  - Requesters must not make req_valid depend on req_ready.
  - Once asserted, req_valid and operands stay stable until accepted.
- Transfer: occurs when req_valid[g] & req_ready[g].
  - Next edge: out_valid=1, out_data=(a_g&b_g)|(c_g&d_g), out_id=g, acc_cnt+=1 (wraps at 2^CNTW), ptr=(g+1) mod NREQ.
- Latency: 1 cycle from accept edge to out_valid. Throughput is 1 result/cycle when out_ready is held high.
- Backpressure: while out_valid & !out_ready:
  - out_data and out_id hold.
  - No grant is issued; req_ready=0.
  - ptr holds.
- Simultaneous drain and accept: out_valid & out_ready & new grant in the same cycle loads the new result; out_valid stays 1 with no bubble.
- Drain without accept: out_valid falls to 0 on the next edge. out_data and out_id keep their last value; they are don't-care for checking.
- No requests: ptr and acc_cnt unchanged.
- Fairness:
  - With all NREQ requesters continuously valid and out_ready=1, grants cycle 0,1,...,NREQ-1,0,...
  - No requester waits more than NREQ-1 grants.
- Reset mid-operation: any held result is discarded (out_valid=0) and ptr returns to 0. Requesters must re-present if required.
- Arithmetic: bitwise and-or only, with no carry. out_id is zero-extended to IDW.

Decomposition:
- Shared package and_or_pkg holds:
  - the default WIDTH and NREQ constants;
  - a function and_or_f(a,b,c,d) returning (a&b)|(c&d), reused by other and-or blocks.
- One sub-module is natural: rr_pick.
  - Parameter NREQ.
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant, grant index, any.
  - It is purely combinational and is reused for other arbiters.
- Pointer, output register and counter stay in and_or_rr_sched.

Test Plan (NREQ=4, WIDTH=8):
1. Reset:
   - Stimulus: assert rst for 2 cycles with all req_valid=1.
   - Response: req_ready=0000, out_valid=0, out_data=0, acc_cnt=0. Then release rst.
2. Single request:
   - Stimulus: req 2 with a=F0, b=3C, c=0F, d=AA, out_ready=1.
   - Response: req_ready=0100 that cycle. Next cycle out_valid=1, out_data=3A, out_id=2, acc_cnt=1.
3. Fairness:
   - Stimulus: all four valid continuously, out_ready=1.
   - Response: out_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles; acc_cnt=8 after 8 grants.
4. Backpressure:
   - Stimulus: result held with out_ready=0 for 3 cycles while req 1 and req 3 are valid.
   - Response: out_data/out_id stable and req_ready=0000 for those 3 cycles. On out_ready=1 the same cycle grants per ptr with no bubble.
5. Wrap and skip:
   - Stimulus: ptr=3 (after grant to 2), only req 1 valid.
   - Response: req 1 granted, out_id=1, ptr becomes 2.
6. Reset mid-operation:
   - Stimulus: out_valid=1 with out_id=3, assert rst one cycle.
   - Response: out_valid=0, acc_cnt=0. With all requesters valid afterwards, the first grant is requester 0.

Source files
------------

// File: rtl/and_or_pkg.sv
// Shared definitions for the and-or evaluation blocks.
package and_or_pkg;

    // Default geometry of an and-or scheduler instance.
    localparam int unsigned AO_NREQ  = 4;
    localparam int unsigned AO_WIDTH = 8;
    localparam int unsigned AO_CNTW  = 16;

    // Widest operand the shared helper handles; narrower users zero-extend
    // their operands and truncate the result.
    localparam int unsigned AO_MAXW  = 64;

    typedef logic [AO_MAXW-1:0] ao_word_t;

    // Bitwise (a&b)|(c&d); there is no carry, so zero-extension is harmless.
    function automatic ao_word_t and_or_f(
        input ao_word_t a,
        input ao_word_t b,
        input ao_word_t c,
        input ao_word_t d
    );
        return (a & b) | (c & d);
    endfunction

endpackage

// File: rtl/and_or_rr_sched_if.sv
// Request/result bundle between the requesters, the scheduler and the
// downstream consumer.
interface and_or_rr_sched_if
    import and_or_pkg::*;
#(
    parameter int unsigned NREQ  = AO_NREQ,
    parameter int unsigned WIDTH = AO_WIDTH,
    parameter int unsigned CNTW  = AO_CNTW
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*WIDTH-1:0] req_c;
    logic [NREQ*WIDTH-1:0] req_d;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic [CNTW-1:0]       acc_cnt;

    // Requesters and consumer side.
    modport master (
        output req_valid, req_a, req_b, req_c, req_d, out_ready,
        input  req_ready, out_valid, out_data, out_id, acc_cnt
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, req_c, req_d, out_ready,
        output req_ready, out_valid, out_data, out_id, acc_cnt
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_req scanning from
// i_ptr upward with wrap-around modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    // Rotated priority scan; the first hit wins.
    always_comb begin
        logic           w_found;
        logic [IDW-1:0] w_pos;
        o_gnt   = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_pos = IDW'((32'(i_ptr) + k) % NREQ);
            if (i_en && !w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/and_or_rr_sched.sv
// Round-robin scheduler sharing one registered and-or stage among NREQ
// requesters; the result leaves through a single-entry output register.
module and_or_rr_sched
    import and_or_pkg::*;
#(
    parameter int unsigned NREQ  = AO_NREQ,
    parameter int unsigned WIDTH = AO_WIDTH,
    parameter int unsigned CNTW  = AO_CNTW,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    and_or_rr_sched_if.slave bus
);

    logic [IDW-1:0]   r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [IDW-1:0]   r_out_id;
    logic [CNTW-1:0]  r_cnt;

    logic             w_slot_free;
    logic             w_en;
    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_res;

    // A grant is only possible when the output slot empties this cycle.
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_en        = w_slot_free && !rst;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .i_en  (w_en),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // The picker only grants valid requesters, so the grant is the transfer.
    assign bus.req_ready = w_gnt;

    assign w_a = bus.req_a[w_idx*WIDTH +: WIDTH];
    assign w_b = bus.req_b[w_idx*WIDTH +: WIDTH];
    assign w_c = bus.req_c[w_idx*WIDTH +: WIDTH];
    assign w_d = bus.req_d[w_idx*WIDTH +: WIDTH];
    assign w_res = WIDTH'(and_or_f(AO_MAXW'(w_a), AO_MAXW'(w_b),
                                   AO_MAXW'(w_c), AO_MAXW'(w_d)));

    assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    // Output register, priority pointer and accept counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_cnt       <= '0;
        end else if (w_any) begin
            r_ptr       <= w_ptr_nxt;
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_out_id    <= w_idx;
            r_cnt       <= r_cnt + 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_id    = r_out_id;
    assign bus.acc_cnt   = r_cnt;

endmodule
